io_out_fifo: RTL and testbench

//  Output buffer between the core's OUT path and io_data_out (the AXI UART-Lite TX stage in io_controller).
//  - Absorbs bursts of core OUT requests into a FIFO, so the core stalls only when the FIFO is full.
//  - Replays the buffered words one at a time into io_data_out's out_req/out_busy handshake.
//  - Sits directly upstream of io_data_out; its out_* ports connect 1:1 to io_data_out's out_req/out_data/out_busy.

---
 rtl/io_out_fifo_if.sv | 23 ++
 rtl/io_out_fifo.sv | 86 ++++++++
 tb/tb_io_out_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/io_out_fifo_if.sv
// Handshake bundle between the core OUT path, the output FIFO and io_data_out.
// slave  : the FIFO's view (takes core pushes, drives the io_data_out request).
// master : the surrounding environment's view (core + io_data_out).
interface io_out_fifo_if #(
  parameter int DATA_W = 8
);
  logic              core_out_req;
  logic [DATA_W-1:0] core_out_data;
  logic              core_out_busy;
  logic              out_req;
  logic [DATA_W-1:0] out_data;
  logic              out_busy;

  modport slave (
    input  core_out_req, core_out_data, out_busy,
    output core_out_busy, out_req, out_data
  );

  modport master (
    output core_out_req, core_out_data, out_busy,
    input  core_out_busy, out_req, out_data
  );
endinterface

// File: rtl/io_out_fifo.sv
// Output FIFO between the core OUT path and io_data_out.
// Core pushes land in a register array; a 2-state FSM replays them one word
// at a time as single-cycle out_req pulses, waiting for out_busy to drop.
module io_out_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  io_out_fifo_if.slave          bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);
  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_L   = (DEPTH_LOG2+1)'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state, state_nxt;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_ptr, wr_ptr;
  logic                    full_q;
  logic                    push, drop, pop;
  logic [DEPTH_LOG2:0]     level_nxt;

  // Full flag is a register so core_out_busy never depends on core_out_req.
  assign bus.core_out_busy = full_q;

  // Push/drop qualification, FSM next state and pop decision.
  always_comb begin
    push      = bus.core_out_req && !full_q;
    drop      = bus.core_out_req && full_q;
    pop       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (level != '0 && !bus.out_busy) begin
        pop       = 1'b1;
        state_nxt = REQ;
      end
      // out_busy reads high from our own request here, so it is not consulted.
      REQ:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + ONE_L;
      2'b01:   level_nxt = level - ONE_L;
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.core_out_data;
  end

  // Pointers, occupancy, flags, FSM state and the registered request pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      full_q       <= 1'b0;
      overflow     <= 1'b0;
      bus.out_req  <= 1'b0;
      bus.out_data <= '0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      full_q      <= (level_nxt == DEPTH_L);
      bus.out_req <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        bus.out_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_io_out_fifo.sv
// Bench for io_out_fifo: directed steps plus randomized bursts, checked
// against a queue model of the FIFO and a simple io_data_out busy model.
module tb_io_out_fifo;
  logic             clk = 1'b0;
  logic             rstn;
  logic [4:0]       level;
  logic             overflow;

  io_out_fifo_if #(.DATA_W(8)) bus();

  io_out_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // io_data_out model: busy while req is high, then for a random hold time.
  logic hold_busy;
  int   blen_lo, blen_hi;
  int   bcnt;
  assign bus.out_busy = hold_busy | bus.out_req | (bcnt != 0);

  always @(posedge clk) begin
    if (!rstn)            bcnt <= 0;
    else if (bus.out_req) bcnt <= $urandom_range(blen_hi, blen_lo);
    else if (bcnt > 0)    bcnt <= bcnt - 1;
  end

  // Reference model: a 16-entry queue, pushes dropped when it is full.
  logic [7:0] q[$];
  logic       exp_ovf;
  logic       mon_en;
  logic       prev_req;
  int         pops;

  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      exp_ovf <= 1'b0;
    end else if (bus.core_out_req) begin
      if (q.size() < 16) q.push_back(bus.core_out_data);
      else               exp_ovf <= 1'b1;
    end
  end

  // Scoreboard: every request must carry the oldest queued word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_req) begin
        chk("pop_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("pop_data", bus.out_data, q.pop_front());
        pops <= pops + 1;
      end
      chk("pulse_1cyc", prev_req & bus.out_req, 0);
      chk("level", level, q.size());
      chk("core_busy", bus.core_out_busy, q.size() == 16);
      chk("overflow", overflow, exp_ovf);
      chk("level_max", level <= 16, 1);
      prev_req <= bus.out_req;
    end
  end

  initial begin
    int guard;
    int p0;
    int sent;
    rstn = 1'b0;
    bus.core_out_req = 1'b0;
    bus.core_out_data = 8'h00;
    hold_busy = 1'b0;
    blen_lo = 6; blen_hi = 6;
    mon_en = 1'b0;
    prev_req = 1'b0;
    pops = 0;

    // 1: reset then idle
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_out_req", bus.out_req, 0);
    chk("rst_level", level, 0);
    chk("rst_core_busy", bus.core_out_busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", bus.out_data, 0);

    // 2: single word latency
    bus.core_out_req = 1'b1; bus.core_out_data = 8'h41;
    @(negedge clk);
    bus.core_out_req = 1'b0;
    chk("t2_level_t1", level, 1);
    chk("t2_req_t1", bus.out_req, 0);
    @(negedge clk);
    chk("t2_req_t2", bus.out_req, 1);
    chk("t2_data_t2", bus.out_data, 8'h41);
    @(negedge clk);
    chk("t2_req_t3", bus.out_req, 0);
    chk("t2_level_t3", level, 0);
    chk("t2_data_hold", bus.out_data, 8'h41);
    repeat (10) @(negedge clk);

    // 3: fill to full with io_data_out stalled
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.core_out_req = 1'b1; bus.core_out_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    bus.core_out_req = 1'b0;
    @(negedge clk);
    chk("t3_level_full", level, 16);
    chk("t3_core_busy", bus.core_out_busy, 1);
    chk("t3_no_ovf", overflow, 0);
    chk("t3_no_req", bus.out_req, 0);

    // 4: push into a full FIFO is dropped
    bus.core_out_req = 1'b1; bus.core_out_data = 8'hEE;
    @(negedge clk);
    bus.core_out_req = 1'b0;
    chk("t4_ovf", overflow, 1);
    chk("t4_level", level, 16);

    // 3 (cont): drain with 6 busy cycles per word
    @(posedge clk); #1 p0 = pops;
    @(negedge clk);
    hold_busy = 1'b0;
    guard = 0;
    while ((q.size() != 0 || bus.out_busy) && guard < 400) begin
      @(negedge clk); guard++;
    end
    chk("t3_drain_timeout", guard < 400, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("t3_pop_count", pops - p0, 16);
    chk("t3_level_empty", level, 0);

    // 5: random pushes while draining, pointers wrap
    blen_lo = 1; blen_hi = 2;
    p0 = pops;
    sent = 0;
    while (sent < 20) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0 && q.size() < 12) begin
        bus.core_out_req = 1'b1; bus.core_out_data = 8'($urandom);
        sent++;
      end else begin
        bus.core_out_req = 1'b0;
      end
    end
    @(negedge clk);
    bus.core_out_req = 1'b0;
    guard = 0;
    while ((q.size() != 0 || bus.out_busy) && guard < 400) begin
      @(negedge clk); guard++;
    end
    chk("t5_drain_timeout", guard < 400, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("t5_pop_count", pops - p0, 20);

    // 6: reset during REQ with 5 words left
    @(negedge clk);
    hold_busy = 1'b1;
    blen_lo = 6; blen_hi = 6;
    for (int i = 0; i < 6; i++) begin
      bus.core_out_req = 1'b1; bus.core_out_data = 8'(8'h60 + i);
      @(negedge clk);
    end
    bus.core_out_req = 1'b0;
    hold_busy = 1'b0;
    guard = 0;
    while (!bus.out_req && guard < 50) begin
      @(negedge clk); guard++;
    end
    chk("t6_req_timeout", guard < 50, 1);
    chk("t6_level_in_req", level, 5);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("t6_req_after_rst", bus.out_req, 0);
    chk("t6_level_after_rst", level, 0);
    chk("t6_ovf_after_rst", overflow, 0);
    @(posedge clk); #1 p0 = pops;
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    chk("t6_no_stale", pops - p0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
